// File: rtl/tmds_video_sequencer.sv
// tmds_video_sequencer: raster timing generator and pixel scheduler feeding three TMDS encoders.
// Ports:
//   clk, rst_n           pixel/encoder clock, asynchronous active-low reset
//   i_enable             run request (dropping it lets the current frame finish)
//   i_pix_data/valid     upstream pixel {R,G,B} with valid; o_pix_ready accepts it
//   i_clr_underflow      clears the sticky underflow flag
//   o_vd_r/g/b, o_vde    encoder video data and shared video-enable (registered)
//   o_cd_r/g/b           encoder control data; blue carries {vsync,hsync}
//   o_frame_start        pulse coincident with the first active pixel of a frame
//   o_underflow          sticky: an active pixel found no valid data
//   o_busy               sequencer not idle
module tmds_video_sequencer #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_enable,
    input  logic [23:0] i_pix_data,
    input  logic        i_pix_valid,
    output logic        o_pix_ready,
    input  logic        i_clr_underflow,
    output logic [7:0]  o_vd_r,
    output logic [7:0]  o_vd_g,
    output logic [7:0]  o_vd_b,
    output logic [1:0]  o_cd_r,
    output logic [1:0]  o_cd_g,
    output logic [1:0]  o_cd_b,
    output logic        o_vde,
    output logic        o_frame_start,
    output logic        o_underflow,
    output logic        o_busy
);
    localparam logic [11:0] H_LAST = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [11:0] V_LAST = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [1:0]  CD_IDLE = {~VS_POL, ~HS_POL};

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t      r_state, w_state_nxt;
    logic [11:0] r_hcnt, r_vcnt, w_hcnt_nxt, w_vcnt_nxt;
    logic        r_vde, r_frame_start, r_underflow;
    logic [7:0]  r_vd_r, r_vd_g, r_vd_b;
    logic [1:0]  r_cd_b;
    logic        w_run, w_h_end, w_v_end, w_active, w_hs, w_vs, w_xfer;

    assign w_run    = r_state != IDLE;
    assign w_h_end  = r_hcnt == H_LAST;
    assign w_v_end  = r_vcnt == V_LAST;
    assign w_active = w_run && r_hcnt < 12'(H_ACTIVE) && r_vcnt < 12'(V_ACTIVE);
    assign w_hs     = w_run && r_hcnt >= 12'(H_ACTIVE + H_FP) && r_hcnt < 12'(H_ACTIVE + H_FP + H_SYNC);
    assign w_vs     = w_run && r_vcnt >= 12'(V_ACTIVE + V_FP) && r_vcnt < 12'(V_ACTIVE + V_FP + V_SYNC);
    assign w_xfer   = w_active && i_pix_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_hcnt  <= '0;
            r_vcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hcnt  <= w_hcnt_nxt;
            r_vcnt  <= w_vcnt_nxt;
        end
    end

    // DRAIN keeps the raster running so a stopped stream always ends on a frame boundary.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    w_state_nxt = i_enable ? RUN : IDLE;
            RUN:     w_state_nxt = i_enable ? RUN : DRAIN;
            DRAIN:   w_state_nxt = i_enable ? RUN : (w_h_end && w_v_end) ? IDLE : DRAIN;
            default: w_state_nxt = IDLE;
        endcase
        w_hcnt_nxt = (!w_run || w_h_end) ? 12'd0 : r_hcnt + 12'd1;
        w_vcnt_nxt = !w_run ? 12'd0 : !w_h_end ? r_vcnt : w_v_end ? 12'd0 : r_vcnt + 12'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vde         <= 1'b0;
            r_vd_r        <= '0;
            r_vd_g        <= '0;
            r_vd_b        <= '0;
            r_cd_b        <= CD_IDLE;
            r_frame_start <= 1'b0;
            r_underflow   <= 1'b0;
        end else begin
            r_vde         <= w_active;
            r_vd_r        <= w_xfer ? i_pix_data[23:16] : 8'h00;
            r_vd_g        <= w_xfer ? i_pix_data[15:8]  : 8'h00;
            r_vd_b        <= w_xfer ? i_pix_data[7:0]   : 8'h00;
            r_cd_b        <= {w_vs ? VS_POL : ~VS_POL, w_hs ? HS_POL : ~HS_POL};
            r_frame_start <= w_run && r_hcnt == 12'd0 && r_vcnt == 12'd0;
            // a fresh underflow outranks a simultaneous clear
            r_underflow   <= (w_active && !i_pix_valid) ? 1'b1 : i_clr_underflow ? 1'b0 : r_underflow;
        end
    end

    assign o_pix_ready   = w_active;
    assign o_vde         = r_vde;
    assign o_vd_r        = r_vd_r;
    assign o_vd_g        = r_vd_g;
    assign o_vd_b        = r_vd_b;
    assign o_cd_r        = 2'b00;
    assign o_cd_g        = 2'b00;
    assign o_cd_b        = r_cd_b;
    assign o_frame_start = r_frame_start;
    assign o_underflow   = r_underflow;
    assign o_busy        = w_run;
endmodule

// File: tb/tb_tmds_video_sequencer.sv
// tb_tmds_video_sequencer: scoreboard bench for the shrunk 8x6 raster configuration.
module tb_tmds_video_sequencer;
    logic        clk = 1'b0, rst_n = 1'b0, i_enable = 1'b0, i_pix_valid = 1'b0, i_clr_underflow = 1'b0;
    logic [23:0] i_pix_data = '0;
    logic        o_pix_ready, o_vde, o_frame_start, o_underflow, o_busy;
    logic [7:0]  o_vd_r, o_vd_g, o_vd_b;
    logic [1:0]  o_cd_r, o_cd_g, o_cd_b;

    tmds_video_sequencer #(
        .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
        .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_pix_data(i_pix_data),
        .i_pix_valid(i_pix_valid), .o_pix_ready(o_pix_ready), .i_clr_underflow(i_clr_underflow),
        .o_vd_r(o_vd_r), .o_vd_g(o_vd_g), .o_vd_b(o_vd_b),
        .o_cd_r(o_cd_r), .o_cd_g(o_cd_g), .o_cd_b(o_cd_b),
        .o_vde(o_vde), .o_frame_start(o_frame_start), .o_underflow(o_underflow), .o_busy(o_busy)
    );

    always #5 clk = ~clk;

    int          checks = 0, errors = 0;
    int          k = -1;
    bit          running = 1'b0;
    logic [7:0]  ramp = 8'd1;
    logic [23:0] q[$];
    logic [23:0] exp_px = '0;

    // raster position p counts cycles since RUN began: h = p%8, v = (p/8)%6
    function automatic bit exp_act(input int p);
        if (p < 0) return 1'b0;
        return (p % 8 < 4) && ((p / 8) % 6 < 3);
    endfunction

    function automatic logic [1:0] exp_cd(input int p);
        if (p < 0) return 2'b11;
        return {!((p / 8) % 6 == 4), !(p % 8 == 5 || p % 8 == 6)};
    endfunction

    function automatic bit exp_fs(input int p);
        return p >= 0 && p % 48 == 0;
    endfunction

    task automatic tick(input bit val);
        logic [23:0] d;
        d = {~ramp, ramp ^ 8'h5a, ramp};
        i_pix_valid = val;
        i_pix_data  = d;
        if (running && exp_act(k)) q.push_back(val ? d : 24'h0);
        ramp = ramp + 8'd1;
        @(posedge clk); #1;
        if (running) k++;
        exp_px = 24'h0;
        if (running && exp_act(k - 1) && q.size() > 0) exp_px = q.pop_front();
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (o_vde !== 1'b0) begin errors++; $display("FAIL reset_vde got %b exp 0", o_vde); end
        checks++; if ({o_vd_r, o_vd_g, o_vd_b} !== 24'h0) begin errors++; $display("FAIL reset_vd got %h exp 0", {o_vd_r, o_vd_g, o_vd_b}); end
        checks++; if (o_cd_b !== 2'b11) begin errors++; $display("FAIL reset_cd_b got %b exp 11", o_cd_b); end
        checks++; if ({o_cd_r, o_cd_g} !== 4'b0) begin errors++; $display("FAIL reset_cd_rg got %b exp 0", {o_cd_r, o_cd_g}); end
        checks++; if ({o_frame_start, o_underflow, o_busy, o_pix_ready} !== 4'b0) begin errors++; $display("FAIL reset_flags got %b exp 0000", {o_frame_start, o_underflow, o_busy, o_pix_ready}); end
        rst_n = 1'b1;
        tick(1'b1);
        tick(1'b1);
        checks++; if (o_busy !== 1'b0 || o_vde !== 1'b0) begin errors++; $display("FAIL idle_no_enable busy %b vde %b exp 0 0", o_busy, o_vde); end
    endtask

    task automatic test_frame;
        int xfer = 0, fs_cnt = 0;
        i_enable = 1'b1;
        running  = 1'b1;
        k        = -1;
        for (int i = 0; i < 98; i++) begin
            checks++; if (o_pix_ready !== exp_act(k)) begin errors++; $display("FAIL frame_ready k=%0d got %b exp %b", k, o_pix_ready, exp_act(k)); end
            checks++; if (o_vde !== exp_act(k - 1)) begin errors++; $display("FAIL frame_vde k=%0d got %b exp %b", k, o_vde, exp_act(k - 1)); end
            checks++; if (o_cd_b !== exp_cd(k - 1)) begin errors++; $display("FAIL frame_cd_b k=%0d got %b exp %b", k, o_cd_b, exp_cd(k - 1)); end
            checks++; if ({o_cd_r, o_cd_g} !== 4'b0) begin errors++; $display("FAIL frame_cd_rg k=%0d got %b exp 0", k, {o_cd_r, o_cd_g}); end
            checks++; if (o_frame_start !== exp_fs(k - 1)) begin errors++; $display("FAIL frame_start k=%0d got %b exp %b", k, o_frame_start, exp_fs(k - 1)); end
            checks++; if ({o_vd_r, o_vd_g, o_vd_b} !== exp_px) begin errors++; $display("FAIL frame_vd k=%0d got %h exp %h", k, {o_vd_r, o_vd_g, o_vd_b}, exp_px); end
            checks++; if (o_busy !== (k >= 0)) begin errors++; $display("FAIL frame_busy k=%0d got %b exp %b", k, o_busy, k >= 0); end
            if (k >= 0 && k < 48 && o_pix_ready) xfer++;
            if (o_frame_start) fs_cnt++;
            tick(1'b1);
        end
        checks++; if (xfer != 12) begin errors++; $display("FAIL frame_transfers got %0d exp 12", xfer); end
        checks++; if (fs_cnt != 2) begin errors++; $display("FAIL frame_start_count got %0d exp 2", fs_cnt); end
        checks++; if (o_underflow !== 1'b0) begin errors++; $display("FAIL frame_no_underflow got %b exp 0", o_underflow); end
    endtask

    task automatic test_underflow;
        while (k % 48 != 0) tick(1'b1);
        checks++; if (o_underflow !== 1'b0) begin errors++; $display("FAIL uf_pre got %b exp 0", o_underflow); end
        tick(1'b1);
        tick(1'b0);
        checks++; if ({o_vd_r, o_vd_g, o_vd_b} !== 24'h0 || o_vde !== 1'b1) begin errors++; $display("FAIL uf_pixel vd %h vde %b exp 0 1", {o_vd_r, o_vd_g, o_vd_b}, o_vde); end
        checks++; if (o_underflow !== 1'b1) begin errors++; $display("FAIL uf_set got %b exp 1", o_underflow); end
        tick(1'b1);
        checks++; if (o_underflow !== 1'b1) begin errors++; $display("FAIL uf_sticky got %b exp 1", o_underflow); end
        checks++; if ({o_vd_r, o_vd_g, o_vd_b} !== exp_px) begin errors++; $display("FAIL uf_next_vd got %h exp %h", {o_vd_r, o_vd_g, o_vd_b}, exp_px); end
        i_clr_underflow = 1'b1;
        tick(1'b1);
        i_clr_underflow = 1'b0;
        checks++; if (o_underflow !== 1'b0) begin errors++; $display("FAIL uf_clear got %b exp 0", o_underflow); end
        while (!exp_act(k)) tick(1'b1);
        i_clr_underflow = 1'b1;
        tick(1'b0);
        checks++; if (o_underflow !== 1'b1) begin errors++; $display("FAIL uf_clear_vs_new got %b exp 1", o_underflow); end
        checks++; if ({o_vd_r, o_vd_g, o_vd_b} !== 24'h0) begin errors++; $display("FAIL uf_pixel2 got %h exp 0", {o_vd_r, o_vd_g, o_vd_b}); end
        tick(1'b1);
        i_clr_underflow = 1'b0;
        checks++; if (o_underflow !== 1'b0) begin errors++; $display("FAIL uf_clear2 got %b exp 0", o_underflow); end
    endtask

    task automatic test_drain;
        while (k % 48 != 20) tick(1'b1);
        i_enable = 1'b0;
        do begin
            tick(1'b1);
            if (k % 48 != 0) begin
                checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL drain_busy k=%0d got %b exp 1", k, o_busy); end
                checks++; if (o_vde !== exp_act(k - 1)) begin errors++; $display("FAIL drain_vde k=%0d got %b exp %b", k, o_vde, exp_act(k - 1)); end
                checks++; if ({o_vd_r, o_vd_g, o_vd_b} !== exp_px) begin errors++; $display("FAIL drain_vd k=%0d got %h exp %h", k, {o_vd_r, o_vd_g, o_vd_b}, exp_px); end
            end
        end while (k % 48 != 0);
        checks++; if (o_busy !== 1'b0 || o_pix_ready !== 1'b0) begin errors++; $display("FAIL drain_idle busy %b ready %b exp 0 0", o_busy, o_pix_ready); end
        running = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick(1'b1);
            checks++; if ({o_vde, o_frame_start, o_busy, o_pix_ready} !== 4'b0) begin errors++; $display("FAIL idle_flags got %b exp 0000", {o_vde, o_frame_start, o_busy, o_pix_ready}); end
            checks++; if (o_cd_b !== 2'b11 || {o_vd_r, o_vd_g, o_vd_b} !== 24'h0) begin errors++; $display("FAIL idle_levels cd_b %b vd %h exp 11 0", o_cd_b, {o_vd_r, o_vd_g, o_vd_b}); end
        end
    endtask

    task automatic test_back_to_back;
        int fs_cnt = 0;
        i_enable = 1'b1;
        running  = 1'b1;
        k        = -1;
        q.delete();
        while (k != 30) tick(1'b1);
        i_enable = 1'b0;
        repeat (3) tick(1'b1);
        i_enable = 1'b1;
        for (int i = 0; i < 60; i++) begin
            tick(1'b1);
            checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL b2b_busy k=%0d got %b exp 1", k, o_busy); end
            checks++; if (o_vde !== exp_act(k - 1) || o_frame_start !== exp_fs(k - 1)) begin errors++; $display("FAIL b2b_timing k=%0d vde %b fs %b exp %b %b", k, o_vde, o_frame_start, exp_act(k - 1), exp_fs(k - 1)); end
            checks++; if ({o_vd_r, o_vd_g, o_vd_b} !== exp_px) begin errors++; $display("FAIL b2b_vd k=%0d got %h exp %h", k, {o_vd_r, o_vd_g, o_vd_b}, exp_px); end
            if (o_frame_start) fs_cnt++;
        end
        checks++; if (fs_cnt != 1) begin errors++; $display("FAIL b2b_frame_starts got %0d exp 1", fs_cnt); end
    endtask

    task automatic test_async_reset;
        while (k % 48 != 0) tick(1'b1);
        tick(1'b0);
        checks++; if (o_underflow !== 1'b1 || o_vde !== 1'b1) begin errors++; $display("FAIL ar_pre uf %b vde %b exp 1 1", o_underflow, o_vde); end
        rst_n = 1'b0;
        #1;
        checks++; if ({o_vde, o_frame_start, o_underflow, o_busy, o_pix_ready} !== 5'b0) begin errors++; $display("FAIL ar_flags got %b exp 00000", {o_vde, o_frame_start, o_underflow, o_busy, o_pix_ready}); end
        checks++; if ({o_vd_r, o_vd_g, o_vd_b} !== 24'h0 || o_cd_b !== 2'b11) begin errors++; $display("FAIL ar_levels vd %h cd_b %b exp 0 11", {o_vd_r, o_vd_g, o_vd_b}, o_cd_b); end
        running = 1'b0;
        q.delete();
        exp_px = '0;
        @(posedge clk); #1;
        rst_n   = 1'b1;
        running = 1'b1;
        k       = -1;
        for (int i = 0; i < 12; i++) begin
            tick(1'b1);
            checks++; if (o_vde !== exp_act(k - 1) || o_frame_start !== exp_fs(k - 1)) begin errors++; $display("FAIL ar_restart k=%0d vde %b fs %b exp %b %b", k, o_vde, o_frame_start, exp_act(k - 1), exp_fs(k - 1)); end
            checks++; if ({o_vd_r, o_vd_g, o_vd_b} !== exp_px) begin errors++; $display("FAIL ar_vd k=%0d got %h exp %h", k, {o_vd_r, o_vd_g, o_vd_b}, exp_px); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_frame;
        test_underflow;
        test_drain;
        test_back_to_back;
        test_async_reset;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
